// File: rtl/systolic_data_setup.sv
// Diagonal-skew feeder for the weight-stationary systolic array: row r of each
// accepted vector is delayed r shifts, then zero vectors flush the array before Done.
module systolic_data_setup #(
   parameter int DATA_WIDTH = 8,
   parameter int SA_LENGTH  = 256
) (
   input  logic                         CLK,
   input  logic                         ASYNC_RST,
   input  logic                         SYNC_RST,
   input  logic                         In_Valid,
   output logic                         In_Ready,
   input  logic                         In_Last,
   input  logic signed [DATA_WIDTH-1:0] In_Data [SA_LENGTH],
   output logic signed [DATA_WIDTH-1:0] Inputs  [SA_LENGTH],
   output logic                         Array_En,
   output logic                         Busy,
   output logic                         Done
);

   localparam int DRAIN_CYCLES = 2 * SA_LENGTH - 1;
   localparam int CNT_W        = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] drain_cnt;
   logic             accept, shift, drain_end;

   assign In_Ready  = (state != DRAIN) && !SYNC_RST;
   assign Busy      = (state != IDLE);
   assign accept    = In_Valid && In_Ready;
   assign shift     = accept || (state == DRAIN);
   assign drain_end = (state == DRAIN) && (drain_cnt == LAST_CNT);

   // Control registers: state, drain counter, array enable and done pulse
   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         state     <= IDLE;
         drain_cnt <= '0;
         Array_En  <= 1'b0;
         Done      <= 1'b0;
      end else if (SYNC_RST) begin
         state     <= IDLE;
         drain_cnt <= '0;
         Array_En  <= 1'b0;
         Done      <= 1'b0;
      end else begin
         state    <= state_next;
         Array_En <= shift;
         Done     <= drain_end;
         if (state == DRAIN)
            drain_cnt <= drain_end ? '0 : drain_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = In_Last ? DRAIN : STREAM;
         end
         STREAM: begin
            if (accept && In_Last) state_next = DRAIN;
         end
         DRAIN: begin
            if (drain_end) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Skew chain: row r holds r+1 stages and only advances on shift, so stalls keep the skew
   for (genvar r = 0; r < SA_LENGTH; r++) begin : g_row
      logic signed [DATA_WIDTH-1:0] pipe [r+1];

      always_ff @(posedge CLK or negedge ASYNC_RST) begin
         if (!ASYNC_RST) begin
            for (int s = 0; s <= r; s++) pipe[s] <= '0;
         end else if (SYNC_RST) begin
            for (int s = 0; s <= r; s++) pipe[s] <= '0;
         end else if (shift) begin
            pipe[0] <= accept ? In_Data[r] : '0;
            for (int s = 1; s <= r; s++) pipe[s] <= pipe[s-1];
         end
      end

      assign Inputs[r] = pipe[r];
   end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Self-checking bench for systolic_data_setup (SA_LENGTH=4, DATA_WIDTH=8).
module tb_systolic_data_setup;

   localparam int DW    = 8;
   localparam int SA    = 4;
   localparam int DRAIN = 2 * SA - 1;

   logic CLK = 1'b0;
   logic ASYNC_RST, SYNC_RST, In_Valid, In_Ready, In_Last, Array_En, Busy, Done;
   logic signed [DW-1:0] In_Data [SA];
   logic signed [DW-1:0] Inputs  [SA];

   int n_vec = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   systolic_data_setup #(.DATA_WIDTH(DW), .SA_LENGTH(SA)) dut (
      .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Last(In_Last),
      .In_Data(In_Data), .Inputs(Inputs),
      .Array_En(Array_En), .Busy(Busy), .Done(Done)
   );

   // Reference: history of shifted slices, newest first; row r shows the slice from r shifts ago
   logic signed [DW-1:0] hist [SA][SA];
   bit m_en, m_done, m_open;
   int m_left;

   function automatic void model_clear();
      for (int k = 0; k < SA; k++)
         for (int r = 0; r < SA; r++) hist[k][r] = '0;
      m_en = 0; m_done = 0; m_open = 0; m_left = 0;
   endfunction

   function automatic bit model_ready();
      return (m_left == 0) && !SYNC_RST;
   endfunction

   function automatic void model_edge();
      bit acc, drn;
      if (!ASYNC_RST || SYNC_RST) begin
         model_clear();
         return;
      end
      acc = In_Valid && (m_left == 0);
      drn = (m_left > 0);
      if (acc || drn) begin
         for (int k = SA - 1; k > 0; k--) hist[k] = hist[k-1];
         for (int r = 0; r < SA; r++) hist[0][r] = acc ? In_Data[r] : '0;
      end
      m_en   = acc || drn;
      m_done = drn && (m_left == 1);
      if (drn) m_left--;
      if (acc) begin
         if (In_Last) begin
            m_left = DRAIN;
            m_open = 0;
         end else begin
            m_open = 1;
         end
      end
   endfunction

   function automatic logic [31:0] pack_dut();
      logic [31:0] p;
      for (int r = 0; r < SA; r++) p[r*DW +: DW] = Inputs[r];
      return p;
   endfunction

   function automatic logic [31:0] pack_model();
      logic [31:0] p;
      for (int r = 0; r < SA; r++) p[r*DW +: DW] = hist[r][r];
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input bit v, input bit l, input logic [31:0] d);
      In_Valid = v;
      In_Last  = l;
      for (int r = 0; r < SA; r++) In_Data[r] = d[r*DW +: DW];
   endtask

   task automatic tick(input bit use_model);
      @(posedge CLK);
      model_edge();
      #1;
      if (use_model) begin
         chk("inputs", pack_dut(), pack_model());
         chk("array_en", 32'(Array_En), 32'(m_en));
         chk("done", 32'(Done), 32'(m_done));
         chk("in_ready", 32'(In_Ready), 32'(model_ready()));
         chk("busy", 32'(Busy), 32'(m_open || (m_left > 0)));
      end
   endtask

   typedef struct {
      bit          v;
      bit          l;
      logic [31:0] d;
      logic [31:0] e_in;
      bit          e_en;
      bit          e_done;
      bit          e_rdy;
   } vec_t;

   vec_t tbl [18];

   initial begin
      logic [31:0] tiles [2];
      logic [31:0] mask;
      int          seen;

      // Table: single tile {1,2,3,4} and signed extremes {-128,127,-1,0}, one row per cycle
      tiles[0] = {8'd4, 8'd3, 8'd2, 8'd1};
      tiles[1] = {8'h00, 8'hFF, 8'h7F, 8'h80};
      for (int t = 0; t < 2; t++) begin
         for (int j = 0; j < 9; j++) begin
            mask = 32'hFF;
            mask = mask << (j * 8);
            tbl[t*9+j].v      = (j == 0);
            tbl[t*9+j].l      = (j == 0);
            tbl[t*9+j].d      = (j == 0) ? tiles[t] : 32'h0;
            tbl[t*9+j].e_in   = (j < SA) ? (tiles[t] & mask) : 32'h0;
            tbl[t*9+j].e_en   = (j <= 7);
            tbl[t*9+j].e_done = (j == 7);
            tbl[t*9+j].e_rdy  = (j >= 7);
         end
      end

      ASYNC_RST = 1'b0;
      SYNC_RST  = 1'b0;
      drive(0, 0, 32'h0);
      model_clear();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      ASYNC_RST = 1'b1;

      // Reset mid-cycle after random traffic
      for (int i = 0; i < 6; i++) begin
         drive(1'($urandom), 1'($urandom), $urandom);
         tick(1);
      end
      drive(1, 0, $urandom);
      #3;
      ASYNC_RST = 1'b0;
      model_clear();
      #1;
      chk("arst_inputs", pack_dut(), 32'h0);
      chk("arst_en", 32'(Array_En), 32'h0);
      chk("arst_done", 32'(Done), 32'h0);
      ASYNC_RST = 1'b1;
      #1;
      chk("arst_ready", 32'(In_Ready), 32'h1);
      drive(0, 0, 32'h0);
      tick(1);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].l, tbl[i].d);
         tick(0);
         chk("tbl_inputs", pack_dut(), tbl[i].e_in);
         chk("tbl_en", 32'(Array_En), 32'(tbl[i].e_en));
         chk("tbl_done", 32'(Done), 32'(tbl[i].e_done));
         chk("tbl_ready", 32'(In_Ready), 32'(tbl[i].e_rdy));
      end

      // Four back-to-back vectors Vk[r] = 10k + r
      for (int k = 0; k < 4; k++) begin
         drive(1, k == 3, {8'(10*k+3), 8'(10*k+2), 8'(10*k+1), 8'(10*k)});
         tick(1);
      end
      chk("b2b_diag", pack_dut(), {8'd3, 8'd12, 8'd21, 8'd30});
      drive(0, 0, 32'h0);
      seen = 0;
      for (int c = 5; c <= 20; c++) begin
         tick(1);
         if (Done && seen == 0) seen = c;
      end
      chk("b2b_done_cycle", 32'(seen), 32'd11);

      // Bubble of three cycles between V0 and V1
      drive(1, 0, {8'd8, 8'd7, 8'd6, 8'd5});
      tick(1);
      drive(0, 0, 32'h0);
      for (int g = 0; g < 3; g++) begin
         tick(1);
         chk("bubble_en", 32'(Array_En), 32'h0);
         chk("bubble_frozen", pack_dut(), {24'h0, 8'd5});
      end
      drive(1, 1, {8'd18, 8'd17, 8'd16, 8'd15});
      tick(1);
      drive(0, 0, 32'h0);
      for (int c = 0; c < 10; c++) tick(1);

      // Asynchronous reset in the middle of a drain: no Done may follow
      drive(1, 1, {8'd44, 8'd33, 8'd22, 8'd11});
      tick(1);
      drive(0, 0, 32'h0);
      tick(1);
      tick(1);
      #3;
      ASYNC_RST = 1'b0;
      model_clear();
      #1;
      chk("drain_arst_inputs", pack_dut(), 32'h0);
      chk("drain_arst_en", 32'(Array_En), 32'h0);
      chk("drain_arst_busy", 32'(Busy), 32'h0);
      ASYNC_RST = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         if (Done) seen = 1;
      end
      chk("drain_arst_no_done", 32'(seen), 32'h0);

      // Synchronous reset while streaming with a vector offered
      drive(1, 0, {8'd4, 8'd3, 8'd2, 8'd1});
      tick(1);
      drive(1, 0, {8'd9, 8'd9, 8'd9, 8'd9});
      SYNC_RST = 1'b1;
      #1;
      chk("srst_ready", 32'(In_Ready), 32'h0);
      tick(1);
      SYNC_RST = 1'b0;
      drive(0, 0, 32'h0);
      chk("srst_inputs", pack_dut(), 32'h0);
      chk("srst_busy", 32'(Busy), 32'h0);
      chk("srst_en", 32'(Array_En), 32'h0);

      // Randomized traffic against the reference
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 3) != 0, ($urandom % 6) == 0, $urandom);
         SYNC_RST = (($urandom % 60) == 0);
         tick(1);
      end
      SYNC_RST = 1'b0;
      drive(0, 0, 32'h0);
      for (int c = 0; c < 12; c++) tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
